// File: rtl/hex_report_sequencer_if.sv
// Request/stream bundle for hex_report_sequencer.
// master: the sensor-side requesters plus the byte sink (drives requests, tx_ready).
// slave : the sequencer itself (grants requests, drives the byte stream).
interface hex_report_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*8-1:0]      req_tag;
  logic [7:0]                tx_byte;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      busy;

  modport master (
    output req_valid, req_data, req_tag, tx_ready,
    input  req_ready, tx_byte, tx_valid, busy
  );

  modport slave (
    input  req_valid, req_data, req_tag, tx_ready,
    output req_ready, tx_byte, tx_valid, busy
  );
endinterface

// File: rtl/hex_report_sequencer.sv
// hex_report_sequencer: round-robin arbiter in front of one hex-ASCII framer.
// Each accepted report becomes "<tag>:<hex digits>\r\n" on a ready/valid byte stream.
// Optional build macro HEX_REPORT_ZERO_SUPPRESS_EN: drop leading zero digits
// (an all-zero payload still emits a single '0').
//
// state | meaning
// IDLE  | no frame; req_ready offers the round-robin grant
// TAG   | tag byte on tx_byte
// COLON | ':' on tx_byte
// DIGIT | hex digit for nibble cnt_q on tx_byte
// CR    | 0x0D on tx_byte
// LF    | 0x0A on tx_byte; accept returns to IDLE
module hex_report_sequencer #(
  parameter int DATA_W  = 16,
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hex_report_sequencer_if.slave   bus
);

  localparam int DIGITS = DATA_W / 4;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PTR_W  = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TAG   = 3'd1,
    COLON = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic [7:0]          tag_q;
  logic [7:0]          tx_byte_q;
  logic                tx_valid_q;

  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [CNT_W-1:0]    first_idx;
  logic                accept;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic [3:0] nib_at(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] idx);
    return d[4*int'(idx) +: 4];
  endfunction

  assign accept = tx_valid_q & bus.tx_ready;

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  // Index of the first digit to send once the colon is accepted.
  always_comb begin
`ifdef HEX_REPORT_ZERO_SUPPRESS_EN
    first_idx = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if (data_q[4*j +: 4] != 4'h0) first_idx = CNT_W'(j);
    end
`else
    first_idx = CNT_W'(DIGITS - 1);
`endif
  end

  // Grants are only offered in IDLE; gating with rst_n keeps them low during reset.
  assign bus.req_ready = (state_q == IDLE && rst_n) ? grant_oh : '0;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.busy      = (state_q != IDLE);

  // Frame sequencer with registered byte outputs; each state moves on only when its byte is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            data_q     <= bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
            tag_q      <= bus.req_tag[int'(grant_idx)*8 +: 8];
            rr_ptr_q   <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
            tx_byte_q  <= bus.req_tag[int'(grant_idx)*8 +: 8];
            tx_valid_q <= 1'b1;
            state_q    <= TAG;
          end
        end
        TAG: begin
          if (accept) begin
            tx_byte_q <= 8'h3A;
            state_q   <= COLON;
          end
        end
        COLON: begin
          if (accept) begin
            cnt_q     <= first_idx;
            tx_byte_q <= hex_ascii(nib_at(data_q, first_idx));
            state_q   <= DIGIT;
          end
        end
        DIGIT: begin
          if (accept) begin
            if (cnt_q == '0) begin
              tx_byte_q <= 8'h0D;
              state_q   <= CR;
            end else begin
              cnt_q     <= cnt_q - 1'b1;
              tx_byte_q <= hex_ascii(nib_at(data_q, cnt_q - 1'b1));
            end
          end
        end
        CR: begin
          if (accept) begin
            tx_byte_q <= 8'h0A;
            state_q   <= LF;
          end
        end
        LF: begin
          if (accept) begin
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_report_sequencer.sv
// Bench for hex_report_sequencer: frame-level reference model plus directed scenarios.
module tb_hex_report_sequencer;

  localparam int DATA_W  = 16;
  localparam int NUM_REQ = 4;
  localparam int DIGITS  = DATA_W / 4;

  logic clk;
  logic rst_n;

  hex_report_sequencer_if #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) bus ();

  hex_report_sequencer #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];   // bytes the model still expects to see accepted
  logic [7:0] acc_q[$];   // every byte the DUT actually handed over
  int         mptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] hex_char(input int n);
    string h;
    h = "0123456789ABCDEF";
    return h[n];
  endfunction

  // Expand a report into the bytes it must produce on the stream.
  function automatic void build_frame(input logic [7:0] tag, input logic [DATA_W-1:0] d);
    int n;
    int v;
    exp_q.push_back(tag);
    exp_q.push_back(8'h3A);
    v = int'(d);
    n = DIGITS;
`ifdef HEX_REPORT_ZERO_SUPPRESS_EN
    n = 1;
    for (int j = 0; j < DIGITS; j++)
      if (((v >> (4*j)) & 15) != 0) n = j + 1;
`endif
    for (int j = n - 1; j >= 0; j--)
      exp_q.push_back(hex_char((v >> (4*j)) & 15));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Per-cycle comparison against the frame model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    int gi;
    if (bus.tx_valid && bus.tx_ready && rst_n) acc_q.push_back(bus.tx_byte);
    if (!rst_n) begin
      chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
      chk("rst_tx_byte", {24'b0, bus.tx_byte}, 32'd0);
      chk("rst_req_ready", {28'b0, bus.req_ready}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      exp_q.delete();
      mptr = 0;
    end else if (exp_q.size() == 0) begin
      eg = '0;
      gi = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (mptr + k) % NUM_REQ;
        if (gi < 0 && bus.req_valid[idx]) gi = idx;
      end
      if (gi >= 0) eg[gi] = 1'b1;
      chk("idle_req_ready", {28'b0, bus.req_ready}, {28'b0, eg});
      chk("idle_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
      chk("idle_busy", {31'b0, bus.busy}, 32'd0);
      if (gi >= 0) begin
        build_frame(bus.req_tag[gi*8 +: 8], bus.req_data[gi*DATA_W +: DATA_W]);
        mptr = (gi + 1) % NUM_REQ;
      end
    end else begin
      chk("frame_tx_valid", {31'b0, bus.tx_valid}, 32'd1);
      chk("frame_tx_byte", {24'b0, bus.tx_byte}, {24'b0, exp_q[0]});
      chk("frame_req_ready", {28'b0, bus.req_ready}, 32'd0);
      chk("frame_busy", {31'b0, bus.busy}, 32'd1);
      if (bus.tx_ready) void'(exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.tx_valid) done = 1'b1;
    end
    chk({name, "_idle_timeout"}, {31'b0, done}, 32'd1);
    step();
  endtask

  // Compare the accepted bytes from position rd on against a literal string.
  task automatic chk_bytes(input string name, input int rd, input string s);
    chk({name, "_len"}, acc_q.size() - rd, s.len());
    for (int i = 0; i < s.len(); i++) begin
      if (rd + i < acc_q.size())
        chk({name, "_byte"}, {24'b0, acc_q[rd+i]}, {24'b0, s[i]});
    end
  endtask

  initial begin
    int rd;
    int n;
    int s;
    int hs;
    bit seen;
    string exp_s;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_tag   = '0;
    bus.tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_byte", {24'b0, bus.tx_byte}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single frame, continuous tx_ready; payload changes right after acceptance.
    rd = acc_q.size();
    bus.req_data[1*DATA_W +: DATA_W] = 16'h1A3F;
    bus.req_tag[1*8 +: 8]            = 8'h54;
    bus.tx_ready  = 1'b1;
    bus.req_valid = 4'b0010;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      seen = bus.req_ready[1];
      if (seen) n++;
      step();
      if (seen) begin
        bus.req_valid = '0;
        bus.req_data[1*DATA_W +: DATA_W] = 16'hDEAD;
      end
    end
    chk("single_grant_cycles", n, 1);
    wait_idle("single");
    chk_bytes("single", rd, "T:1A3F\015\012");

    // Backpressure: three stall cycles before every accept.
    rd = acc_q.size();
    bus.req_data[1*DATA_W +: DATA_W] = 16'h1A3F;
    bus.tx_ready  = 1'b0;
    bus.req_valid = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.req_ready[1];
      step();
    end
    chk("bp_grant_seen", {31'b0, seen}, 32'd1);
    bus.req_valid = '0;
    n = 0;
    s = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      bus.tx_ready = (s == 3);
      @(negedge clk);
      if (!bus.tx_valid) begin
        seen = 1'b1;
      end else begin
        n++;
        s = bus.tx_ready ? 0 : s + 1;
      end
      if (!seen) step();
    end
    chk("bp_cycles", n, 32);
    wait_idle("bp");
    chk_bytes("bp", rd, "T:1A3F\015\012");

    // Reset mid-frame: all four requesting; rr pointer currently sits at requester 2.
    bus.req_data  = {16'h00B2, 16'h0000, 16'hFFFF, 16'h9F0A};
    bus.req_tag   = {8'h44, 8'h43, 8'h42, 8'h41};
    bus.tx_ready  = 1'b1;
    bus.req_valid = 4'b1111;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready && bus.tx_byte == 8'h3A) seen = 1'b1;
    end
    chk("midframe_colon_seen", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    chk("async_req_ready", {28'b0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd = acc_q.size();

    // Round robin from requester 0 after reset: A,B,C,D,A back to back.
    hs = 0;
    for (int i = 0; i < 300 && hs < 5; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) hs++;
      step();
    end
    bus.req_valid = '0;
    chk("rr_grants", hs, 5);
    wait_idle("rr");
`ifdef HEX_REPORT_ZERO_SUPPRESS_EN
    exp_s = {"A:9F0A\015\012", "B:FFFF\015\012", "C:0\015\012", "D:B2\015\012", "A:9F0A\015\012"};
`else
    exp_s = {"A:9F0A\015\012", "B:FFFF\015\012", "C:0000\015\012", "D:00B2\015\012", "A:9F0A\015\012"};
`endif
    chk_bytes("rr", rd, exp_s);
    chk("model_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
